lpc_reg_bank: RTL and testbench
===============================

LPC_REG_BANK -- requirements
Module: lpc_reg_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock port LpcClock, reset port PciReset.
REQ-002 Parameters SHALL be as follows (name, default, meaning):
- NUM_REGS, 32: implemented registers, range 8..256.
- ID_VALUE, 8'h10: read-only value of reg 0x00.
- KEY_ADDR, 8'h07: address of the unlock key register.
- PROT_LO, 8'h10: first write-protected address.
- PROT_HI, 8'h1F: last write-protected address.
- UNLOCK_CYCLES, 1024: unlock window length in LpcClock cycles.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- LpcClock, in, 1: 33 MHz LPC clock.
- PciReset, in, 1: asynchronous active-low reset.
- Addr, in, 8: register address.
- Wr, in, 1: single-cycle write strobe.
- Rd, in, 1: single-cycle read strobe.
- DataWr, in, 8: write data.
- DataRd, out, 8: read data.
- RdValid, out, 1: read data valid.
- Pwr_ok, in, 1: power good.
- StatusIn, in, 8: hardware event pulses into the status register.
- Active_Bios, out, 1: selected BIOS chip.
- Unlocked, out, 1: protected range is writable.
- WrErr, out, 1: rejected-write pulse.

Function
REQ-004 A write SHALL update only the register addressed by Addr (address decode), in the cycle after Wr is sampled high.
REQ-005 Addr >= NUM_REGS SHALL be out of range: writes are ignored with a WrErr pulse, and reads return 8'hFF.
REQ-006 A read SHALL have 1-cycle latency: DataRd and RdValid are registered, RdValid is high for exactly one cycle, and DataRd holds its value until the next read.
REQ-007 Wr and Rd high in the same cycle to the same address SHALL return the pre-write value.
REQ-008 Reg 0x00 SHALL be read-only and read ID_VALUE; a write to it is ignored with a WrErr pulse.
REQ-009 Reg 0x04 SHALL be BIOS control, with bit0 = Active_Bios (read-only), bit1 = Next_Bios (R/W), and bits7:2 reading 0.
REQ-010 A Next_Bios latch (no reset) SHALL sample reg 0x04 bit1 every cycle while PciReset is high, and hold while PciReset is low.
REQ-011 Reg 0x05 SHALL be the status register:
- A StatusIn[i] high sets bit i.
- Writing 1 to bit i clears it.
- A set and a clear of the same bit in the same cycle: the set wins.
REQ-012 Reg KEY_ADDR SHALL be the key register, reading the current FSM state encoding {6'b0, state}.
REQ-013 The unlock FSM SHALL have three states: LOCKED=0, KEY1=1, UNLOCKED=2.
- LOCKED: key write 8'h55 -> KEY1; any other key write stays in LOCKED.
- KEY1: key write 8'hAA -> UNLOCKED and loads the countdown with UNLOCKED_CYCLES-1; any other key write -> LOCKED; a non-key write leaves the state unchanged.
- UNLOCKED: the countdown decrements each cycle; at 0 -> LOCKED; any key write -> LOCKED immediately.
REQ-014 Unlocked SHALL be high exactly when the FSM state is UNLOCKED.
REQ-015 Writes to PROT_LO..PROT_HI SHALL take effect only while Unlocked is high; otherwise they are ignored with a WrErr pulse.
REQ-016 A protected write in the same cycle the countdown reaches 0 SHALL be accepted.
REQ-017 All other registers SHALL be plain 8-bit R/W.
REQ-018 WrErr SHALL be registered, high for one cycle per rejected write.
REQ-019 The countdown SHALL be $clog2(UNLOCK_CYCLES) bits wide and SHALL NOT wrap below 0.

Reset
REQ-020 While PciReset is low, all flops except the Next_Bios latch SHALL take their reset values asynchronously:
- DataRd=8'h00, RdValid=0, WrErr=0.
- FSM=LOCKED, countdown=0.
REQ-021 Register reset values SHALL be:
- 0x01=8'h55, 0x02=8'hAA, 0x03=8'h66.
- 0x05=8'h00, KEY_ADDR=8'h00.
- All others 8'h00.
REQ-022 Reg 0x04 SHALL reset with b = Pwr_ok & Next_Bios_latch:
- bit0 = b.
- bit1 = b.
- Active_Bios follows bit0.
REQ-023 Reset asserted mid-unlock SHALL return the FSM to LOCKED, and a write in flight during reset SHALL be discarded.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then read 0x00/0x01/0x04 with Pwr_ok=1 and latch=0 -> 8'h10, 8'h55, 8'h00; Active_Bios=0.
- Write 0x04=8'h02, pulse PciReset, Pwr_ok=1 -> reg 0x04 reads 8'h03, Active_Bios=1; repeat with Pwr_ok=0 -> reads 8'h00.
- Write 0x12=8'h3C while LOCKED -> WrErr one cycle, reads 8'h00; then key 8'h55, 8'hAA, write 0x12=8'h3C -> reads 8'h3C, Unlocked=1.
- Unlocked: after UNLOCK_CYCLES cycles -> Unlocked=0 and key reads 8'h00; key 8'h55 then 8'h11 -> state LOCKED.
- StatusIn=8'h81 pulse -> 0x05 reads 8'h81; write 8'h01 with StatusIn[0]=1 in the same cycle -> 8'h81; write 8'h81 alone -> 8'h00.
- Write and read Addr=8'h40 with NUM_REGS=32 -> WrErr pulse, DataRd=8'hFF, RdValid for one cycle.

Source files
------------

// File: rtl/lpc_reg_bank.sv
// -----------------------------------------------------------------------------
// lpc_reg_bank
//
// Byte-wide register bank on the LPC clock. It provides a read-only ID
// register, BIOS chip selection that survives reset through an unreset sample
// of Next_Bios, a write-1-to-clear status register fed by event pulses, and a
// key-unlocked window that allows writes to a protected address range.
//
// Ports
//   LpcClock     in   1  LPC clock
//   PciReset     in   1  asynchronous active-low reset
//   Addr         in   8  register address
//   Wr           in   1  single-cycle write strobe
//   Rd           in   1  single-cycle read strobe
//   DataWr       in   8  write data
//   DataRd       out  8  registered read data, held until the next read
//   RdValid      out  1  one-cycle pulse, one cycle after Rd
//   Pwr_ok       in   1  power good, qualifies the boot BIOS choice
//   StatusIn     in   8  event pulses that set status register bits
//   Active_Bios  out  1  BIOS chip selected at the last reset
//   Unlocked     out  1  protected range is writable
//   WrErr        out  1  one-cycle pulse per rejected write
// -----------------------------------------------------------------------------
module lpc_reg_bank #(
  parameter int         NUM_REGS      = 32,
  parameter logic [7:0] ID_VALUE      = 8'h10,
  parameter logic [7:0] KEY_ADDR      = 8'h07,
  parameter logic [7:0] PROT_LO       = 8'h10,
  parameter logic [7:0] PROT_HI       = 8'h1F,
  parameter int         UNLOCK_CYCLES = 1024
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic [7:0] Addr,
  input  logic       Wr,
  input  logic       Rd,
  input  logic [7:0] DataWr,
  output logic [7:0] DataRd,
  output logic       RdValid,
  input  logic       Pwr_ok,
  input  logic [7:0] StatusIn,
  output logic       Active_Bios,
  output logic       Unlocked,
  output logic       WrErr
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

  localparam logic [8:0]       REG_LIMIT = 9'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [7:0] ADDR_ID     = 8'h00;
  localparam logic [7:0] ADDR_BIOS   = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h05;
  localparam logic [7:0] KEY_FIRST   = 8'h55;
  localparam logic [7:0] KEY_SECOND  = 8'hAA;

  // Unlock FSM encoding; visible to software through the key register.
  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_KEY1     = 2'd1;
  localparam logic [1:0] ST_UNLOCKED = 2'd2;

  function automatic logic [7:0] reg_reset_val(input int idx);
    case (idx)
      1:       return 8'h55;
      2:       return 8'hAA;
      3:       return 8'h66;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]       r_regs [NUM_REGS];
  logic [7:0]       r_status;
  logic             r_next_bios;
  logic             r_bios_active;
  logic             r_next_bios_latch;
  logic             r_run;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_data_rd;
  logic             r_rd_valid;
  logic             r_wr_err;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] w_idx;
  logic             w_in_range;
  logic             w_is_id;
  logic             w_is_key;
  logic             w_is_bios;
  logic             w_is_status;
  logic             w_is_plain;
  logic             w_is_prot;
  logic             w_unlocked;
  logic             w_wr_reject;
  logic             w_wr_accept;
  logic             w_key_wr;
  logic             w_bios_wr;
  logic             w_status_wr;
  logic             w_plain_wr;
  logic             w_boot_bios;
  logic [7:0]       w_status_clr;
  logic [7:0]       w_rd_data;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_idx       = Addr[IDX_W-1:0];
  assign w_in_range  = ({1'b0, Addr} < REG_LIMIT);
  assign w_is_id     = (Addr == ADDR_ID);
  assign w_is_key    = (Addr == KEY_ADDR) & ~w_is_id;
  assign w_is_bios   = (Addr == ADDR_BIOS) & ~w_is_key;
  assign w_is_status = (Addr == ADDR_STATUS) & ~w_is_key;
  assign w_is_plain  = ~(w_is_id | w_is_key | w_is_bios | w_is_status);
  // The key register is never protected, otherwise the range could not be
  // unlocked if it happened to overlap the key address.
  assign w_is_prot   = (Addr >= PROT_LO) && (Addr <= PROT_HI) && !w_is_key;
  assign w_unlocked  = (r_state == ST_UNLOCKED);

  // Protection is judged on the current state, so a write in the final
  // unlocked cycle (countdown at 0) is still accepted.
  assign w_wr_reject = Wr & (~w_in_range | w_is_id | (w_is_prot & ~w_unlocked));
  assign w_wr_accept = Wr & ~w_wr_reject;
  assign w_key_wr    = w_wr_accept & w_is_key;
  assign w_bios_wr   = w_wr_accept & w_is_bios;
  assign w_status_wr = w_wr_accept & w_is_status;
  assign w_plain_wr  = w_wr_accept & w_is_plain;

  // ---------------------------------------------------------------------------
  // Plain R/W registers
  // ---------------------------------------------------------------------------
  // NOTE: each register is a separate async-reset flop rather than a RAM
  // because every entry needs a defined value straight out of reset.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam logic [7:0] RST_VAL = reg_reset_val(g);
    always_ff @(posedge LpcClock or negedge PciReset) begin
      if (!PciReset) begin
        r_regs[g] <= RST_VAL;
      end else if (w_plain_wr && (w_idx == IDX_W'(g))) begin
        r_regs[g] <= DataWr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status register: event pulses set bits, writing 1 clears them; a set in the
  // same cycle as a clear wins because the OR is applied last.
  // ---------------------------------------------------------------------------
  assign w_status_clr = w_status_wr ? DataWr : 8'h00;

  // NOTE: sequential state is assigned with <= only, so every flop samples the
  // pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_status <= 8'h00;
    end else begin
      r_status <= (r_status & ~w_status_clr) | StatusIn;
    end
  end

  // ---------------------------------------------------------------------------
  // BIOS selection
  // ---------------------------------------------------------------------------
  // The boot choice is the Next_Bios value remembered across reset, only
  // honoured when power is good.
  assign w_boot_bios = Pwr_ok & r_next_bios_latch;

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_bios_active <= w_boot_bios;
      r_next_bios   <= w_boot_bios;
    end else if (w_bios_wr) begin
      r_next_bios   <= DataWr[1];
    end
  end

  // Run flag: low while reset is asserted, high from the first clock after
  // release. It gates the Next_Bios sample so the memory of the selection is
  // frozen for the whole reset period.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Deliberately unreset: this flop is what carries the BIOS choice through a
  // reset. On the first clock after release r_next_bios still equals the boot
  // value, so skipping that one sample loses nothing.
  always_ff @(posedge LpcClock) begin
    if (r_run) begin
      r_next_bios_latch <= r_next_bios;
    end
  end

  // ---------------------------------------------------------------------------
  // Unlock FSM and countdown
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_LOCKED: begin
        if (w_key_wr && (DataWr == KEY_FIRST)) begin
          w_state_nxt = ST_KEY1;
        end
      end
      ST_KEY1: begin
        if (w_key_wr) begin
          if (DataWr == KEY_SECOND) begin
            w_state_nxt = ST_UNLOCKED;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if (w_key_wr || (r_cnt == '0)) begin
          // The counter parks at 0 rather than wrapping.
          w_state_nxt = ST_LOCKED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_state <= ST_LOCKED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: registered, one cycle latency. The mux sees pre-write contents,
  // so a read and write to the same address in one cycle returns the old value.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_data = 8'hFF;
    if (w_in_range) begin
      if (w_is_id) begin
        w_rd_data = ID_VALUE;
      end else if (w_is_key) begin
        w_rd_data = {6'b0, r_state};
      end else if (w_is_bios) begin
        w_rd_data = {6'b0, r_next_bios, r_bios_active};
      end else if (w_is_status) begin
        w_rd_data = r_status;
      end else begin
        w_rd_data = r_regs[w_idx];
      end
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_data_rd  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= Rd;
      r_wr_err   <= w_wr_reject;
      if (Rd) begin
        r_data_rd <= w_rd_data;
      end
    end
  end

  assign DataRd      = r_data_rd;
  assign RdValid     = r_rd_valid;
  assign WrErr       = r_wr_err;
  assign Unlocked    = w_unlocked;
  assign Active_Bios = r_bios_active;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_lpc_reg_bank
//
// Self-checking bench for lpc_reg_bank. Each driven cycle updates a behavioural
// model of the register bank and queues the expected outputs; a monitor running
// on the falling clock edge pops and compares them. Directed scenarios push
// fixed expected read values; the random phase uses the model's value.
// -----------------------------------------------------------------------------
module tb_lpc_reg_bank;

  localparam int         NUM_REGS = 32;
  localparam int         UNLOCK   = 16;
  localparam logic [7:0] ID_VAL   = 8'h10;
  localparam logic [7:0] KEY      = 8'h07;
  localparam logic [7:0] P_LO     = 8'h10;
  localparam logic [7:0] P_HI     = 8'h1F;

  logic       LpcClock = 1'b0;
  logic       PciReset = 1'b1;
  logic [7:0] Addr     = 8'h00;
  logic       Wr       = 1'b0;
  logic       Rd       = 1'b0;
  logic [7:0] DataWr   = 8'h00;
  logic [7:0] DataRd;
  logic       RdValid;
  logic       Pwr_ok   = 1'b0;
  logic [7:0] StatusIn = 8'h00;
  logic       Active_Bios;
  logic       Unlocked;
  logic       WrErr;

  always #5 LpcClock = ~LpcClock;

  lpc_reg_bank #(
    .NUM_REGS     (NUM_REGS),
    .ID_VALUE     (ID_VAL),
    .KEY_ADDR     (KEY),
    .PROT_LO      (P_LO),
    .PROT_HI      (P_HI),
    .UNLOCK_CYCLES(UNLOCK)
  ) dut (
    .LpcClock   (LpcClock),
    .PciReset   (PciReset),
    .Addr       (Addr),
    .Wr         (Wr),
    .Rd         (Rd),
    .DataWr     (DataWr),
    .DataRd     (DataRd),
    .RdValid    (RdValid),
    .Pwr_ok     (Pwr_ok),
    .StatusIn   (StatusIn),
    .Active_Bios(Active_Bios),
    .Unlocked   (Unlocked),
    .WrErr      (WrErr)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic rd_valid;
    logic wr_err;
    logic unlocked;
    logic active;
  } cyc_exp_t;

  cyc_exp_t   exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] hold_val = 8'h00;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: register contents as a byte array, unlock progress as a
  // mode number plus a count of remaining unlocked cycles.
  // ---------------------------------------------------------------------------
  logic [7:0] m_mem[256];
  int         m_mode = 0;   // 0 locked, 1 first key seen, 2 unlocked
  int         m_left = 0;   // unlocked cycles remaining
  logic       m_next = 1'b0;
  logic       m_active = 1'b0;
  logic       m_latch = 1'b0;
  logic [7:0] m_stat = 8'h00;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (int'(a) >= NUM_REGS) return 8'hFF;
    if (a == 8'h00) return ID_VAL;
    if (a == KEY)   return 8'(m_mode);
    if (a == 8'h04) return {6'b0, m_next, m_active};
    if (a == 8'h05) return m_stat;
    return m_mem[a];
  endfunction

  task automatic model_reset(input logic pwr);
    logic b;
    b        = pwr & m_latch;
    m_active = b;
    m_next   = b;
    m_mode   = 0;
    m_left   = 0;
    m_stat   = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_mem[1] = 8'h55;
    m_mem[2] = 8'hAA;
    m_mem[3] = 8'h66;
  endtask

  // One clock cycle of stimulus. Called at a falling edge; returns at the next.
  task automatic cycle(input logic wr, input logic rd, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] st,
                       input bit use_exp = 1'b0, input logic [7:0] exp_rd = 8'h00);
    logic       unlocked_now, prot, reject, accept, latch_new;
    logic [7:0] clr;
    cyc_exp_t   e;
    Wr = wr; Rd = rd; Addr = a; DataWr = d; StatusIn = st;

    unlocked_now = (m_mode == 2);
    prot   = (a >= P_LO) && (a <= P_HI);
    reject = wr && ((int'(a) >= NUM_REGS) || (a == 8'h00) || (prot && !unlocked_now));
    accept = wr && !reject;
    if (rd) rd_q.push_back(use_exp ? exp_rd : m_read(a));

    latch_new = m_next;
    clr    = (accept && a == 8'h05) ? d : 8'h00;
    m_stat = (m_stat & ~clr) | st;
    if (accept && a == 8'h04) m_next = d[1];
    if (accept && a != 8'h04 && a != 8'h05 && a != KEY) m_mem[a] = d;

    if (accept && a == KEY) begin
      if (m_mode == 0) begin
        if (d == 8'h55) m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == 8'hAA) begin
          m_mode = 2;
          m_left = UNLOCK;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_mode = 0;
        m_left = 0;
      end
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    m_latch = latch_new;

    e.rd_valid = rd;
    e.wr_err   = reject;
    e.unlocked = (m_mode == 2);
    e.active   = m_active;
    exp_q.push_back(e);

    @(posedge LpcClock);
    @(negedge LpcClock);
    Wr = 1'b0; Rd = 1'b0; StatusIn = 8'h00;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b0, a, d, 8'h00);
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp);
    cycle(1'b0, 1'b1, a, 8'h00, 8'h00, 1'b1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // Reset pulse; optionally with a write strobe held high throughout.
  task automatic do_reset(input logic pwr, input bit inflight);
    #1;
    Pwr_ok = pwr;
    if (inflight) begin
      Wr = 1'b1; Addr = 8'h15; DataWr = 8'h77;
    end
    #1;
    PciReset = 1'b0;
    #1;
    model_reset(pwr);
    hold_val = 8'h00;
    check("rst_DataRd",      DataRd,      8'h00);
    check("rst_RdValid",     RdValid,     1'b0);
    check("rst_WrErr",       WrErr,       1'b0);
    check("rst_Unlocked",    Unlocked,    1'b0);
    check("rst_Active_Bios", Active_Bios, m_active);
    repeat (2) @(posedge LpcClock);
    @(negedge LpcClock);
    Wr = 1'b0;
    PciReset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    cyc_exp_t   e;
    logic [7:0] ev;
    forever begin
      @(negedge LpcClock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("RdValid",     RdValid,     e.rd_valid);
        check("WrErr",       WrErr,       e.wr_err);
        check("Unlocked",    Unlocked,    e.unlocked);
        check("Active_Bios", Active_Bios, e.active);
        if (RdValid) begin
          if (rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL rd_unexpected: RdValid high with no read outstanding at %0t", $time);
          end else begin
            ev = rd_q.pop_front();
            check("DataRd", DataRd, ev);
            hold_val = ev;
          end
        end else begin
          check("DataRd_hold", DataRd, hold_val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] a, d, st;
    logic       w, r;
    int         sel;

    // Establish Next_Bios latch = 0, then boot with power good.
    do_reset(1'b0, 1'b0);
    idle(3);
    do_reset(1'b1, 1'b0);
    idle(2);
    rd_reg(8'h00, 8'h10);
    rd_reg(8'h01, 8'h55);
    rd_reg(8'h04, 8'h00);
    check("boot0_Active_Bios", Active_Bios, 1'b0);

    // Next_Bios carried through reset.
    wr_reg(8'h04, 8'h02);
    idle(2);
    do_reset(1'b1, 1'b0);
    idle(2);
    rd_reg(8'h04, 8'h03);
    check("boot1_Active_Bios", Active_Bios, 1'b1);
    idle(2);
    do_reset(1'b0, 1'b0);
    idle(2);
    rd_reg(8'h04, 8'h00);
    check("nopwr_Active_Bios", Active_Bios, 1'b0);

    // Protected write while locked, then unlock and retry.
    wr_reg(8'h12, 8'h3C);
    check("locked_WrErr", WrErr, 1'b1);
    idle(1);
    check("locked_WrErr_1cyc", WrErr, 1'b0);
    rd_reg(8'h12, 8'h00);
    wr_reg(KEY, 8'h55);
    rd_reg(KEY, 8'h01);
    wr_reg(KEY, 8'hAA);
    check("unlock_Unlocked", Unlocked, 1'b1);
    wr_reg(8'h12, 8'h3C);
    rd_reg(8'h12, 8'h3C);
    rd_reg(KEY, 8'h02);

    // Window expiry.
    idle(UNLOCK);
    check("expired_Unlocked", Unlocked, 1'b0);
    rd_reg(KEY, 8'h00);

    // Protected write on the last unlocked cycle is accepted; one later is not.
    wr_reg(KEY, 8'h55);
    wr_reg(KEY, 8'hAA);
    idle(UNLOCK - 1);
    check("last_cycle_Unlocked", Unlocked, 1'b1);
    wr_reg(8'h13, 8'h5A);
    check("last_cycle_WrErr", WrErr, 1'b0);
    check("after_last_Unlocked", Unlocked, 1'b0);
    rd_reg(8'h13, 8'h5A);
    wr_reg(8'h14, 8'h99);
    check("post_expiry_WrErr", WrErr, 1'b1);
    rd_reg(8'h14, 8'h00);

    // Bad second key, and key write while unlocked relocks at once.
    wr_reg(KEY, 8'h55);
    wr_reg(KEY, 8'h11);
    rd_reg(KEY, 8'h00);
    wr_reg(KEY, 8'h55);
    wr_reg(KEY, 8'hAA);
    wr_reg(KEY, 8'h00);
    check("relock_Unlocked", Unlocked, 1'b0);

    // Status register set / clear / set-wins.
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h81);
    rd_reg(8'h05, 8'h81);
    cycle(1'b1, 1'b0, 8'h05, 8'h01, 8'h01);
    rd_reg(8'h05, 8'h81);
    wr_reg(8'h05, 8'h81);
    rd_reg(8'h05, 8'h00);

    // Out of range.
    wr_reg(8'h40, 8'h12);
    check("oor_WrErr", WrErr, 1'b1);
    rd_reg(8'h40, 8'hFF);
    check("oor_RdValid", RdValid, 1'b1);
    idle(1);
    check("oor_RdValid_1cyc", RdValid, 1'b0);

    // Read-only ID, and read-during-write returning the old value.
    wr_reg(8'h00, 8'hAB);
    check("id_WrErr", WrErr, 1'b1);
    rd_reg(8'h00, 8'h10);
    wr_reg(8'h08, 8'h11);
    cycle(1'b1, 1'b1, 8'h08, 8'h22, 8'h00, 1'b1, 8'h11);
    rd_reg(8'h08, 8'h22);

    // Reset mid-unlock with a write in flight.
    wr_reg(8'h15, 8'h00);
    wr_reg(KEY, 8'h55);
    wr_reg(KEY, 8'hAA);
    idle(2);
    do_reset(1'b1, 1'b1);
    idle(2);
    rd_reg(KEY, 8'h00);
    rd_reg(8'h15, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1:    a = KEY;
        2:       a = 8'(8'h10 + $urandom_range(0, 15));
        3:       a = 8'h04;
        4:       a = 8'h05;
        5:       a = 8'h00;
        6:       a = 8'($urandom_range(32, 255));
        default: a = 8'($urandom_range(0, 31));
      endcase
      if (a == KEY) begin
        sel = int'($urandom_range(0, 9));
        d = (sel < 4) ? 8'h55 : (sel < 8) ? 8'hAA : 8'($urandom);
      end else begin
        d = 8'($urandom);
      end
      w  = ($urandom_range(0, 99) < 45);
      r  = ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      cycle(w, r, a, d, st);
      if ((i % 200) == 199) begin
        do_reset(logic'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        idle(2);
      end
    end

    idle(2);
    check("reads_drained", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
